// File: rtl/mul16_seq_if.sv
// Request/response bundle between the CPU execute stage and the sequential multiplier.
interface mul16_seq_if;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [31:0] product;
   logic        hi_nz;

   modport master (output start, a, b, input busy, done, product, hi_nz);
   modport slave  (input start, a, b, output busy, done, product, hi_nz);
endinterface

// File: rtl/mul16_seq.sv
// 16x16 unsigned shift-and-add multiplier: one partial-product add per cycle through a
// 16-bit carry-lookahead sum, 17-cycle latency, optional single-cycle zero shortcut.
module mul16_seq #(
   parameter bit ZERO_SKIP = 1'b1
) (
   input logic       clk,
   input logic       reset_n,
   mul16_seq_if.slave bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_nxt;
   logic [15:0] acc, acc_nxt;
   logic [15:0] mq, mq_nxt;
   logic [15:0] mcand, mcand_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [31:0] product, product_nxt;
   logic        hi_nz, hi_nz_nxt;
   logic        done, done_nxt;

   logic [15:0] x, y, s;
   logic        cout;
   logic [31:0] shifted;

   // Four 4-bit groups with group-level lookahead; the carry out of bit 15 is not formed here.
   function automatic logic [15:0] cla_sum(input logic [15:0] op_x, input logic [15:0] op_y);
      logic [14:0] g;
      logic [15:0] p;
      logic [15:0] c;
      logic [3:0]  cg;
      logic        gg, pg;
      g = op_x[14:0] & op_y[14:0];
      p = op_x ^ op_y;
      cg[0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         pg = &p[4*k +: 4];
         cg[k+1] = gg | (pg & cg[k]);
      end
      for (int k = 0; k < 4; k++) begin
         c[4*k] = cg[k];
         for (int j = 0; j < 3; j++) begin
            c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
         end
      end
      return p ^ c;
   endfunction

   assign x       = acc;
   assign y       = mq[0] ? mcand : 16'h0000;
   assign s       = cla_sum(x, y);
   assign cout    = (x[15] & y[15]) | ((x[15] | y[15]) & ~s[15]);
   assign shifted = {cout, s, mq[15:1]};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         acc     <= 16'h0000;
         mq      <= 16'h0000;
         mcand   <= 16'h0000;
         cnt     <= 4'd0;
         product <= 32'h0000_0000;
         hi_nz   <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         acc     <= acc_nxt;
         mq      <= mq_nxt;
         mcand   <= mcand_nxt;
         cnt     <= cnt_nxt;
         product <= product_nxt;
         hi_nz   <= hi_nz_nxt;
         done    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      mq_nxt      = mq;
      mcand_nxt   = mcand;
      cnt_nxt     = cnt;
      product_nxt = product;
      hi_nz_nxt   = hi_nz;
      done_nxt    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (ZERO_SKIP && (bus.a == 16'h0000 || bus.b == 16'h0000)) begin
                  product_nxt = 32'h0000_0000;
                  hi_nz_nxt   = 1'b0;
                  done_nxt    = 1'b1;
               end else begin
                  mcand_nxt = bus.a;
                  mq_nxt    = bus.b;
                  acc_nxt   = 16'h0000;
                  cnt_nxt   = 4'd0;
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            // The multiplier shifts out of mq as the product's low half shifts in behind it.
            acc_nxt = shifted[31:16];
            mq_nxt  = shifted[15:0];
            cnt_nxt = cnt + 4'd1;
            if (cnt == 4'd15) begin
               product_nxt = shifted;
               hi_nz_nxt   = |shifted[31:16];
               done_nxt    = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.busy    = (state == RUN);
   assign bus.done    = done;
   assign bus.product = product;
   assign bus.hi_nz   = hi_nz;

endmodule

// File: tb/tb_mul16_seq.sv
// Randomised and directed bench for mul16_seq, checked against a plain a*b reference
// with the documented 17-cycle (or 1-cycle zero-shortcut) latency.
module tb_mul16_seq;

   logic clk;
   logic reset_n;

   mul16_seq_if bus_skip ();
   mul16_seq_if bus_full ();

   mul16_seq #(.ZERO_SKIP(1'b1)) dut_skip (.clk(clk), .reset_n(reset_n), .bus(bus_skip));
   mul16_seq #(.ZERO_SKIP(1'b0)) dut_full (.clk(clk), .reset_n(reset_n), .bus(bus_full));

   int check_count = 0;
   int pass_count  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed === expected) pass_count++;
      else $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit full, input logic st, input logic [15:0] op_a, input logic [15:0] op_b);
      if (full) begin
         bus_full.start = st;
         bus_full.a     = op_a;
         bus_full.b     = op_b;
      end else begin
         bus_skip.start = st;
         bus_skip.a     = op_a;
         bus_skip.b     = op_b;
      end
   endtask

   task automatic observe(input bit full, output logic busy, output logic done,
                          output logic hi_nz, output logic [31:0] product);
      if (full) begin
         busy = bus_full.busy; done = bus_full.done; hi_nz = bus_full.hi_nz; product = bus_full.product;
      end else begin
         busy = bus_skip.busy; done = bus_skip.done; hi_nz = bus_skip.hi_nz; product = bus_skip.product;
      end
   endtask

   function automatic logic [31:0] ref_product(input logic [15:0] op_a, input logic [15:0] op_b);
      return 32'(op_a) * 32'(op_b);
   endfunction

   function automatic int ref_latency(input bit full, input logic [15:0] op_a, input logic [15:0] op_b);
      return (!full && (op_a == 16'h0 || op_b == 16'h0)) ? 1 : 17;
   endfunction

   // One isolated multiply: start in cycle 0, then scramble the inputs to prove capture.
   task automatic applyStimulus(input bit full, input logic [15:0] op_a, input logic [15:0] op_b, input string tag);
      int          done_cyc = 0;
      int          busy_cycles = 0;
      int          lat;
      logic        bs, dn, hz;
      logic [31:0] pr, expect_p;
      expect_p = ref_product(op_a, op_b);
      lat      = ref_latency(full, op_a, op_b);
      drive(full, 1'b1, op_a, op_b);
      tick();
      drive(full, 1'b0, 16'($urandom()), 16'($urandom()));
      for (int cyc = 1; cyc <= 40; cyc++) begin
         observe(full, bs, dn, hz, pr);
         if (dn) begin
            done_cyc = cyc;
            break;
         end
         if (bs) busy_cycles++;
         tick();
      end
      checkOutput({tag, "_latency"}, 32'(done_cyc), 32'(lat));
      checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(lat - 1));
      checkOutput({tag, "_busy_at_done"}, 32'(bs), 32'd0);
      checkOutput({tag, "_product"}, pr, expect_p);
      checkOutput({tag, "_hi_nz"}, 32'(hz), 32'(|expect_p[31:16]));
      tick();
      observe(full, bs, dn, hz, pr);
      checkOutput({tag, "_done_pulse"}, 32'(dn), 32'd0);
      checkOutput({tag, "_product_held"}, pr, expect_p);
   endtask

   initial begin
      logic        bs, dn, hz;
      logic [31:0] pr;
      logic [15:0] ra, rb;
      int          first_done, done_count;
      logic [31:0] first_prod, second_prod;
      int          second_done;

      // Reset with start asserted on both instances
      reset_n = 1'b0;
      drive(1'b0, 1'b1, 16'd3, 16'd5);
      drive(1'b1, 1'b1, 16'd3, 16'd5);
      tick();
      tick();
      for (int f = 0; f < 2; f++) begin
         observe(f[0], bs, dn, hz, pr);
         checkOutput("reset_busy", 32'(bs), 32'd0);
         checkOutput("reset_done", 32'(dn), 32'd0);
         checkOutput("reset_product", pr, 32'd0);
         checkOutput("reset_hi_nz", 32'(hz), 32'd0);
      end
      reset_n = 1'b1;
      drive(1'b0, 1'b0, 16'd0, 16'd0);
      drive(1'b1, 1'b0, 16'd0, 16'd0);
      tick();

      applyStimulus(1'b0, 16'd3, 16'd5, "mul_3x5");
      applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, "mul_max");
      applyStimulus(1'b0, 16'h8000, 16'h0002, "mul_8000x2");
      applyStimulus(1'b0, 16'h0000, 16'h1234, "zero_skip");
      applyStimulus(1'b1, 16'h0000, 16'h1234, "zero_full");
      applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, "full_max");

      // Start pulse and operand changes while busy must not disturb the run
      drive(1'b0, 1'b1, 16'd7, 16'd9);
      tick();
      drive(1'b0, 1'b0, 16'd0, 16'd0);
      first_done = 0; done_count = 0; first_prod = 32'h0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc == 5) drive(1'b0, 1'b1, 16'd2, 16'd2);
         if (cyc == 6) drive(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
         observe(1'b0, bs, dn, hz, pr);
         if (dn) begin
            done_count++;
            if (first_done == 0) begin
               first_done = cyc;
               first_prod = pr;
            end
         end
         tick();
      end
      checkOutput("busy_start_done_cycle", 32'(first_done), 32'd17);
      checkOutput("busy_start_done_count", 32'(done_count), 32'd1);
      checkOutput("busy_start_product", first_prod, 32'd63);

      // Start held high: back-to-back operations, new operands presented in the done cycle
      drive(1'b0, 1'b1, 16'h0100, 16'h0100);
      tick();
      first_done = 0; second_done = 0; done_count = 0;
      first_prod = 32'h0; second_prod = 32'h0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         observe(1'b0, bs, dn, hz, pr);
         if (dn) begin
            done_count++;
            if (first_done == 0) begin
               first_done = cyc; first_prod = pr;
            end else if (second_done == 0) begin
               second_done = cyc; second_prod = pr;
            end
         end
         if (cyc == 33) checkOutput("b2b_product_held", pr, 32'h0001_0000);
         if (cyc == 17) drive(1'b0, 1'b1, 16'd12, 16'd12);
         if (cyc == 18) drive(1'b0, 1'b0, 16'd12, 16'd12);
         tick();
      end
      checkOutput("b2b_first_cycle", 32'(first_done), 32'd17);
      checkOutput("b2b_first_product", first_prod, 32'h0001_0000);
      checkOutput("b2b_second_cycle", 32'(second_done), 32'd34);
      checkOutput("b2b_second_product", second_prod, 32'd144);
      checkOutput("b2b_done_count", 32'(done_count), 32'd2);

      // Randomised operands on both instances, with zeros injected now and then
      for (int i = 0; i < 24; i++) begin
         ra = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom());
         rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom());
         applyStimulus(i[0], ra, rb, $sformatf("rand%0d", i));
      end

      // Reset in the middle of a run aborts it
      drive(1'b0, 1'b1, 16'hABCD, 16'h1234);
      tick();
      drive(1'b0, 1'b0, 16'h0, 16'h0);
      repeat (7) tick();
      observe(1'b0, bs, dn, hz, pr);
      checkOutput("midreset_running", 32'(bs), 32'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      observe(1'b0, bs, dn, hz, pr);
      checkOutput("midreset_busy", 32'(bs), 32'd0);
      checkOutput("midreset_done", 32'(dn), 32'd0);
      checkOutput("midreset_product", pr, 32'd0);
      checkOutput("midreset_hi_nz", 32'(hz), 32'd0);
      done_count = 0;
      for (int cyc = 0; cyc < 25; cyc++) begin
         observe(1'b0, bs, dn, hz, pr);
         if (dn) done_count++;
         tick();
      end
      checkOutput("midreset_no_done", 32'(done_count), 32'd0);
      applyStimulus(1'b0, 16'hABCD, 16'h1234, "after_reset");

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
